// File: rtl/stump_control_seq.sv
// stump_control_seq: FETCH/EXECUTE/MEMORY sequencer for the Stump datapath.
// Optional macro STUMP_WAITSTATE_EN enables the MEM_RDY stall handshake.
`default_nettype none

module stump_control_seq (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [15:0] IR,
    input  logic [3:0]  CC,
    input  logic        MEM_RDY,
    output logic [1:0]  STATE,
    output logic        IR_CE,
    output logic        PC_CE,
    output logic        REG_WE,
    output logic        CC_CE,
    output logic        MEM_RE,
    output logic        MEM_WE,
    output logic        ADDR_SEL,
    output logic        BR_TAKEN,
    output logic [15:0] INSTR_CNT
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_EXECUTE = 2'b01,
        S_MEMORY  = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    state_t      state;
    logic [15:0] instr_cnt;
    logic        ready;

`ifdef STUMP_WAITSTATE_EN
    assign ready = MEM_RDY;
    logic [8:0] unused_ir;
    assign unused_ir = {IR[12], IR[7:0]};
`else
    assign ready = 1'b1;
    logic [9:0] unused_ir;
    assign unused_ir = {MEM_RDY, IR[12], IR[7:0]};
`endif

    logic [2:0] op;
    logic       is_ldst;
    logic       is_br;
    logic       s_bit;
    logic       flag_n, flag_z, flag_v, flag_c;
    logic       cond;

    assign op      = IR[15:13];
    assign is_ldst = (op == 3'b110);
    assign is_br   = (op == 3'b111);
    assign s_bit   = IR[11];
    assign {flag_n, flag_z, flag_v, flag_c} = CC;

    always_comb begin
        cond = 1'b0;
        case (IR[11:8])
            4'h0: cond = 1'b1;
            4'h1: cond = 1'b0;
            4'h2: cond = ~flag_c & ~flag_z;
            4'h3: cond = flag_c | flag_z;
            4'h4: cond = ~flag_c;
            4'h5: cond = flag_c;
            4'h6: cond = ~flag_z;
            4'h7: cond = flag_z;
            4'h8: cond = ~flag_v;
            4'h9: cond = flag_v;
            4'hA: cond = ~flag_n;
            4'hB: cond = flag_n;
            4'hC: cond = (flag_n == flag_v);
            4'hD: cond = (flag_n != flag_v);
            4'hE: cond = ~flag_z & (flag_n == flag_v);
            4'hF: cond = flag_z | (flag_n != flag_v);
            default: cond = 1'b0;
        endcase
    end

    // Strobes are gated by nRST so nothing fires while reset is held.
    always_comb begin
        IR_CE    = 1'b0;
        PC_CE    = 1'b0;
        REG_WE   = 1'b0;
        CC_CE    = 1'b0;
        MEM_RE   = 1'b0;
        MEM_WE   = 1'b0;
        ADDR_SEL = 1'b0;
        BR_TAKEN = 1'b0;
        if (nRST) begin
            case (state)
                S_FETCH: begin
                    MEM_RE = 1'b1;
                    IR_CE  = ready;
                    PC_CE  = ready;
                end
                S_EXECUTE: begin
                    if (is_br) begin
                        BR_TAKEN = cond;
                        PC_CE    = cond;
                    end else if (!is_ldst) begin
                        REG_WE = 1'b1;
                        CC_CE  = s_bit;
                    end
                end
                S_MEMORY: begin
                    ADDR_SEL = 1'b1;
                    if (s_bit) begin
                        MEM_WE = 1'b1;
                    end else begin
                        MEM_RE = 1'b1;
                        REG_WE = ready;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= S_FETCH;
            instr_cnt <= 16'h0000;
        end else begin
            case (state)
                S_FETCH: begin
                    if (ready) state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (is_ldst) begin
                        state <= S_MEMORY;
                    end else begin
                        state     <= S_FETCH;
                        instr_cnt <= instr_cnt + 16'h0001;
                    end
                end
                S_MEMORY: begin
                    if (ready) begin
                        state     <= S_FETCH;
                        instr_cnt <= instr_cnt + 16'h0001;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    assign STATE     = state;
    assign INSTR_CNT = instr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_stump_control_seq.sv
// tb_stump_control_seq: directed and randomized checks of stump_control_seq
// against an instruction-level reference model.
`default_nettype none

module tb_stump_control_seq;

    logic        CLK;
    logic        nRST;
    logic [15:0] IR;
    logic [3:0]  CC;
    logic        MEM_RDY;
    logic [1:0]  STATE;
    logic        IR_CE, PC_CE, REG_WE, CC_CE, MEM_RE, MEM_WE, ADDR_SEL, BR_TAKEN;
    logic [15:0] INSTR_CNT;

    stump_control_seq dut (
        .CLK(CLK), .nRST(nRST), .IR(IR), .CC(CC), .MEM_RDY(MEM_RDY),
        .STATE(STATE), .IR_CE(IR_CE), .PC_CE(PC_CE), .REG_WE(REG_WE),
        .CC_CE(CC_CE), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .ADDR_SEL(ADDR_SEL),
        .BR_TAKEN(BR_TAKEN), .INSTR_CNT(INSTR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: phase 0 = fetching, 1 = executing, 2 = memory access.
    int          m_phase = 0;
    logic [15:0] m_cnt   = 16'h0000;

`ifdef STUMP_WAITSTATE_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Conditions come in complementary pairs; odd codes invert the even one.
    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit n, z, v, cy, base;
        {n, z, v, cy} = f;
        case (c[3:1])
            3'd0: base = 1'b1;
            3'd1: base = !cy && !z;
            3'd2: base = !cy;
            3'd3: base = !z;
            3'd4: base = !v;
            3'd5: base = !n;
            3'd6: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [7:0] strobes_now();
        return {IR_CE, PC_CE, REG_WE, CC_CE, MEM_RE, MEM_WE, ADDR_SEL, BR_TAKEN};
    endfunction

    // One clock cycle: starts just after a rising edge, ends just after the next.
    task automatic step(input logic [15:0] ir_next, input logic [3:0] cc_v, input logic rdy_v);
        bit rdy, ldst, br, store, tk;
        bit ir_ce, pc_ce, reg_we, cc_ce, mem_re, mem_we, addr_sel, br_t;
        if (m_phase == 0) IR = ir_next;
        CC = cc_v;
        MEM_RDY = rdy_v;
        rdy   = WAIT_EN ? rdy_v : 1'b1;
        ldst  = (IR[15:13] == 3'd6);
        br    = (IR[15:13] == 3'd7);
        store = IR[11];
        tk    = cond_true(IR[11:8], cc_v);
        {ir_ce, pc_ce, reg_we, cc_ce, mem_re, mem_we, addr_sel, br_t} = '0;
        case (m_phase)
            0: begin mem_re = 1; ir_ce = rdy; pc_ce = rdy; end
            1: begin
                if (br) begin br_t = tk; pc_ce = tk; end
                else if (!ldst) begin reg_we = 1; cc_ce = IR[11]; end
            end
            default: begin
                addr_sel = 1;
                if (store) mem_we = 1;
                else begin mem_re = 1; reg_we = rdy; end
            end
        endcase
        @(negedge CLK);
        check_val("state", {14'd0, STATE}, 16'(m_phase));
        check_val("strobes", {8'd0, strobes_now()},
                  {8'd0, ir_ce, pc_ce, reg_we, cc_ce, mem_re, mem_we, addr_sel, br_t});
        check_val("instr_cnt", INSTR_CNT, m_cnt);
        case (m_phase)
            0: if (rdy) m_phase = 1;
            1: if (ldst) m_phase = 2; else begin m_phase = 0; m_cnt++; end
            default: if (rdy) begin m_phase = 0; m_cnt++; end
        endcase
        @(posedge CLK);
        #1;
    endtask

    task automatic run_instr(input logic [15:0] ir, input logic [3:0] cc_v);
        step(ir, cc_v, 1'b1);
        step(ir, cc_v, 1'b1);
        if (ir[15:13] == 3'd6) step(ir, cc_v, 1'b1);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        int k;
        r = 16'($urandom);
        k = $urandom_range(0, 2);
        if (k == 0)      r[15:13] = 3'($urandom_range(0, 5));
        else if (k == 1) r[15:13] = 3'd6;
        else             r[15:13] = 3'd7;
        return r;
    endfunction

    initial begin
        nRST = 1'b0; IR = 16'h0000; CC = 4'h0; MEM_RDY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_state", {14'd0, STATE}, 16'h0000);
        check_val("rst_strobes", {8'd0, strobes_now()}, 16'h0000);
        check_val("rst_cnt", INSTR_CNT, 16'h0000);
        nRST = 1'b1;

        // ALU with and without S, taken/untaken/never branches, load and store.
        run_instr(16'h0A04, 4'h0);
        run_instr(16'h0204, 4'hF);
        run_instr(16'hE712, 4'b0100);
        run_instr(16'hE712, 4'b0000);
        run_instr(16'hE1FF, 4'hF);
        run_instr(16'hE000, 4'h0);
        run_instr(16'hC000, 4'h0);
        run_instr(16'hC800, 4'h0);
        check_val("cnt_after_directed", INSTR_CNT, 16'd8);

        // Stall in FETCH and in MEMORY (no effect unless the handshake is built in).
        repeat (3) step(16'hC000, 4'h0, 1'b0);
        step(16'hC000, 4'h0, 1'b1);
        step(16'hC000, 4'h0, 1'b0);
        repeat (2) step(16'hC000, 4'h0, 1'b0);
        repeat (4) step(16'hC000, 4'h0, 1'b1);

        for (int i = 0; i < 4000; i++)
            step(rand_instr(), 4'($urandom), 1'($urandom_range(0, 3) != 0));

        // Abandon a store while it is in MEMORY.
        while (m_phase != 0) step(16'h0000, 4'h0, 1'b1);
        step(16'hC800, 4'h0, 1'b1);
        step(16'hC800, 4'h0, 1'b1);
        MEM_RDY = 1'b0;
        #2;
        check_val("pre_rst_memwe", {15'd0, MEM_WE}, 16'h0001);
        nRST = 1'b0;
        #1;
        check_val("async_rst_state", {14'd0, STATE}, 16'h0000);
        check_val("async_rst_memwe", {15'd0, MEM_WE}, 16'h0000);
        check_val("async_rst_strobes", {8'd0, strobes_now()}, 16'h0000);
        check_val("async_rst_cnt", INSTR_CNT, 16'h0000);
        m_phase = 0;
        m_cnt = 16'h0000;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int i = 0; i < 200; i++)
            step(rand_instr(), 4'($urandom), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
